// File: rtl/serial_compare_msb_if.sv
// Handshake/data bundle for the MSB-first serial comparator.
// The master drives the operands and start; the slave returns the result.
interface serial_compare_msb_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
);
  localparam int CW = $clog2(WIDTH/STEP) + 1;

  logic             iStart;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic [2:0]       oData;
  logic             oBusy;
  logic             oDone;
  logic [CW-1:0]    oCycles;

  modport master (output iStart, iData_a, iData_b,
                  input  oData, oBusy, oDone, oCycles);
  modport slave  (input  iStart, iData_a, iData_b,
                  output oData, oBusy, oDone, oCycles);
endinterface

// File: rtl/serial_compare_msb.sv
// MSB-first multi-cycle magnitude comparator, STEP bits per clock, early exit
// on the first differing chunk; result code {a>b, a<b, a==b}.
module serial_compare_msb #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                 iClk,
  input  logic                 iRst,
  serial_compare_msb_if.slave  bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_data;
  logic [CW-1:0]    r_cycles;

  logic [STEP-1:0]  w_ca, w_cb;
  assign w_ca = r_sa[WIDTH-1 -: STEP];
  assign w_cb = r_sb[WIDTH-1 -: STEP];

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_cnt    <= '0;
      r_data   <= 3'b000;
      r_cycles <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.iStart) begin
          r_sa    <= bus.iData_a;
          r_sb    <= bus.iData_b;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_ca > w_cb) begin
            r_data   <= 3'b100;
            r_cycles <= r_cnt + CW'(1);
            r_state  <= S_DONE;
          end else if (w_ca < w_cb) begin
            r_data   <= 3'b010;
            r_cycles <= r_cnt + CW'(1);
            r_state  <= S_DONE;
          end else if (r_cnt == CW'(N-1)) begin
            r_data   <= 3'b001;
            r_cycles <= CW'(N);
            r_state  <= S_DONE;
          end else begin
            // equal chunk: expose the next one at the top
            r_sa  <= r_sa << STEP;
            r_sb  <= r_sb << STEP;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oData   = r_data;
  assign bus.oCycles = r_cycles;
  assign bus.oBusy   = (r_state != S_IDLE);
  assign bus.oDone   = (r_state == S_DONE);
endmodule

// File: tb/tb_serial_compare_msb.sv
// Bench for serial_compare_msb: STEP=1 and STEP=4 instances, directed cases
// plus random operands against an arithmetic reference model.
module tb_serial_compare_msb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  serial_compare_msb_if #(.WIDTH(8), .STEP(1)) u_if1 ();
  serial_compare_msb_if #(.WIDTH(8), .STEP(4)) u_if4 ();

  serial_compare_msb #(.WIDTH(8), .STEP(1)) u_dut1 (.iClk(clk), .iRst(rst), .bus(u_if1));
  serial_compare_msb #(.WIDTH(8), .STEP(4)) u_dut4 (.iClk(clk), .iRst(rst), .bus(u_if4));

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b);
    if (sel == 0) begin
      u_if1.iStart = st; u_if1.iData_a = a; u_if1.iData_b = b;
    end else begin
      u_if4.iStart = st; u_if4.iData_a = a; u_if4.iData_b = b;
    end
  endtask

  function automatic int rd_data(input int sel);
    return (sel == 0) ? int'(u_if1.oData) : int'(u_if4.oData);
  endfunction
  function automatic int rd_cyc(input int sel);
    return (sel == 0) ? int'(u_if1.oCycles) : int'(u_if4.oCycles);
  endfunction
  function automatic int rd_busy(input int sel);
    return (sel == 0) ? int'(u_if1.oBusy) : int'(u_if4.oBusy);
  endfunction
  function automatic int rd_done(input int sel);
    return (sel == 0) ? int'(u_if1.oDone) : int'(u_if4.oDone);
  endfunction

  // Reference: m from the highest differing bit, code from plain magnitude compare.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input int step,
                       output int code, output int m);
    logic [7:0] d;
    int h;
    d = a ^ b;
    if (d == 8'h00) begin
      code = 1; m = 8 / step;
    end else begin
      h = 0;
      for (int i = 0; i < 8; i++) if (d[i]) h = i;
      m = (7 - h) / step + 1;
      code = (a > b) ? 4 : 2;
    end
  endtask

  task automatic run_cmp(input int sel, input logic [7:0] a, input logic [7:0] b, input string tag);
    int step, code, m, lat, busy;
    step = (sel == 0) ? 1 : 4;
    model(a, b, step, code, m);
    lat = 0; busy = 0;
    @(negedge clk); drive(sel, 1'b1, a, b);
    @(negedge clk); drive(sel, 1'b0, 8'($urandom), 8'($urandom));
    if (rd_busy(sel) == 1) busy++;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (rd_busy(sel) == 1) busy++;
      if (rd_done(sel) == 1) begin lat = n; break; end
    end
    chk({tag, " latency"}, lat, m);
    chk({tag, " data"}, rd_data(sel), code);
    chk({tag, " cycles"}, rd_cyc(sel), m);
    chk({tag, " busy_len"}, busy, m + 1);
    @(negedge clk);
    chk({tag, " done_pulse"}, rd_done(sel), 0);
    chk({tag, " idle"}, rd_busy(sel), 0);
    chk({tag, " hold"}, rd_data(sel), code);
  endtask

  initial begin
    drive(0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00);
    #12;
    chk("rst_data", rd_data(0), 0);
    chk("rst_busy", rd_busy(0), 0);
    chk("rst_done", rd_done(0), 0);
    chk("rst_cyc", rd_cyc(0), 0);
    @(negedge clk); rst = 1'b0;

    run_cmp(0, 8'hA5, 8'h25, "t1");
    run_cmp(0, 8'h3C, 8'h3D, "t2");
    run_cmp(0, 8'h5A, 8'h5A, "t3");

    // Start held high through RUN/DONE: only re-accepted once back in IDLE.
    @(negedge clk); drive(0, 1'b1, 8'hF0, 8'h0F);
    @(negedge clk); drive(0, 1'b1, 8'h00, 8'hFF);
    @(negedge clk);
    chk("t4 done1", rd_done(0), 1);
    chk("t4 data1", rd_data(0), 4);
    @(negedge clk);
    chk("t4 idle", rd_busy(0), 0);
    chk("t4 hold", rd_data(0), 4);
    @(negedge clk);
    chk("t4 restart", rd_busy(0), 1);
    drive(0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t4 done2", rd_done(0), 1);
    chk("t4 data2", rd_data(0), 2);
    chk("t4 cyc2", rd_cyc(0), 1);

    // Reset in the middle of a RUN.
    @(negedge clk); drive(0, 1'b1, 8'h01, 8'h02);
    @(negedge clk); drive(0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("t5 prebusy", rd_busy(0), 1);
    rst = 1'b1;
    #1;
    chk("t5 busy", rd_busy(0), 0);
    chk("t5 done", rd_done(0), 0);
    chk("t5 data", rd_data(0), 0);
    chk("t5 cyc", rd_cyc(0), 0);
    @(negedge clk); rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("t5 nopulse", rd_done(0), 0);
    end
    run_cmp(0, 8'h02, 8'h01, "t5b");

    run_cmp(1, 8'h7F, 8'h80, "t6a");
    run_cmp(1, 8'h81, 8'h80, "t6b");
    run_cmp(1, 8'hC3, 8'hC3, "t6c");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      case ($urandom_range(0, 2))
        0: b = a;
        1: b = a ^ (8'h01 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      run_cmp(i % 2, a, b, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
